serial_adder24: RTL



---
 rtl/serial_adder24_pkg.sv | 15 +
 rtl/serial_adder24_if.sv | 30 +++
 rtl/serial_adder24_rca.sv | 24 ++
 rtl/serial_adder24.sv | 114 +++++++++++
 4 files changed

// File: rtl/serial_adder24_pkg.sv
// Shared constants and state encoding for the nibble-serial 24-bit add/subtract unit.
package serial_adder24_pkg;

    localparam int WORD_W  = 24;
    localparam int NIB_W   = 4;
    localparam int NIB_CNT = 6;
    localparam int IDX_W   = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

endpackage

// File: rtl/serial_adder24_if.sv
// Start/done request bus between the CPU datapath (master) and the serial adder (slave).
// Handshake: the slave accepts START (with SUB/A/B) on any rising edge where it is idle;
// BUSY marks an operation in progress, DONE is a one-cycle pulse with RESULT and flags valid,
// and RESULT/flags hold until the next accepted START. dbg_state mirrors the FSM state.
interface serial_adder24_if;
    import serial_adder24_pkg::*;

    logic              START;
    logic              SUB;
    logic [WORD_W-1:0] A;
    logic [WORD_W-1:0] B;
    logic              BUSY;
    logic              DONE;
    logic [WORD_W-1:0] RESULT;
    logic              CARRY;
    logic              OVF;
    logic              ZERO;
    state_t            dbg_state;

    modport master (
        output START, SUB, A, B,
        input  BUSY, DONE, RESULT, CARRY, OVF, ZERO, dbg_state
    );

    modport slave (
        input  START, SUB, A, B,
        output BUSY, DONE, RESULT, CARRY, OVF, ZERO, dbg_state
    );

endinterface

// File: rtl/serial_adder24_rca.sv
// The team's 4-bit ripple-carry adder: one nibble slice of the serial datapath.
module Ripple_Carry_Adder
    import serial_adder24_pkg::*;
(
    input  logic [NIB_W-1:0] i_a,
    input  logic [NIB_W-1:0] i_b,
    input  logic             i_cin,
    output logic [NIB_W-1:0] o_sum,
    output logic             o_cout
);

    logic [NIB_W:0] w_c;

    assign w_c[0] = i_cin;

    // Full-adder chain, bit 0 to bit 3.
    for (genvar g = 0; g < NIB_W; g++) begin : g_fa
        assign o_sum[g]   = i_a[g] ^ i_b[g] ^ w_c[g];
        assign w_c[g + 1] = (i_a[g] & i_b[g]) | (w_c[g] & (i_a[g] ^ i_b[g]));
    end

    assign o_cout = w_c[NIB_W];

endmodule

// File: rtl/serial_adder24.sv
// 24-bit add/subtract done one nibble per cycle through a single 4-bit ripple adder.
// Subtraction is A + ~B + 1: B is inverted at acceptance and the carry register seeded with 1.
module serial_adder24
    import serial_adder24_pkg::*;
(
    input  logic            CLK,
    input  logic            RST_N,
    serial_adder24_if.slave bus
);

    state_t            r_state;
    state_t            w_next;
    logic [IDX_W-1:0]  r_idx;
    logic [WORD_W-1:0] r_a_q;
    logic [WORD_W-1:0] r_b_q;
    logic [WORD_W-1:0] r_result;
    logic              r_c_q;
    logic              r_carry;
    logic              r_ovf;
    logic              r_zero;

    logic [NIB_W-1:0]  w_a_nib;
    logic [NIB_W-1:0]  w_b_nib;
    logic [NIB_W-1:0]  w_sum;
    logic              w_cout;
    logic              w_last;
    logic [WORD_W-1:0] w_result_next;

    assign w_last  = (r_idx == IDX_W'(NIB_CNT - 1));
    assign w_a_nib = r_a_q[int'(r_idx) * NIB_W +: NIB_W];
    assign w_b_nib = r_b_q[int'(r_idx) * NIB_W +: NIB_W];

    Ripple_Carry_Adder u_rca (
        .i_a    (w_a_nib),
        .i_b    (w_b_nib),
        .i_cin  (r_c_q),
        .o_sum  (w_sum),
        .o_cout (w_cout)
    );

    // Result with the current nibble merged in; feeds both the result register and the zero flag.
    always_comb begin
        w_result_next = r_result;
        w_result_next[int'(r_idx) * NIB_W +: NIB_W] = w_sum;
    end

    // Next-state logic: accept in IDLE, six RUN cycles, one FIN cycle.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (bus.START) w_next = RUN;
            RUN:     if (w_last) w_next = FIN;
            FIN:     w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) r_state <= IDLE;
        else        r_state <= w_next;
    end

    // Operand latch, nibble counter, carry chain, result assembly and flags.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_idx    <= '0;
            r_a_q    <= '0;
            r_b_q    <= '0;
            r_c_q    <= 1'b0;
            r_result <= '0;
            r_carry  <= 1'b0;
            r_ovf    <= 1'b0;
            r_zero   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.START) begin
                        r_a_q    <= bus.A;
                        r_b_q    <= bus.SUB ? ~bus.B : bus.B;
                        r_c_q    <= bus.SUB;
                        r_idx    <= '0;
                        r_result <= '0;
                        r_carry  <= 1'b0;
                        r_ovf    <= 1'b0;
                        r_zero   <= 1'b0;
                    end
                end
                RUN: begin
                    r_result <= w_result_next;
                    r_c_q    <= w_cout;
                    r_idx    <= r_idx + IDX_W'(1);
                    if (w_last) begin
                        // Overflow is judged on the already-inverted B operand.
                        r_carry <= w_cout;
                        r_ovf   <= (r_a_q[WORD_W-1] == r_b_q[WORD_W-1]) &&
                                   (w_result_next[WORD_W-1] != r_a_q[WORD_W-1]);
                        r_zero  <= ~|w_result_next;
                    end
                end
                default: r_idx <= '0;
            endcase
        end
    end

    assign bus.BUSY      = (r_state == RUN);
    assign bus.DONE      = (r_state == FIN);
    assign bus.RESULT    = r_result;
    assign bus.CARRY     = r_carry;
    assign bus.OVF       = r_ovf;
    assign bus.ZERO      = r_zero;
    assign bus.dbg_state = r_state;

endmodule
